updown_counter_mod: RTL and testbench
=====================================

// Module: updown_counter_mod
// PURPOSE
//  Synchronous modulo-N up/down counter, rising-edge triggered, with parallel
//  load, count enable and terminal-count output.
//  - Consumes the edge-triggered storage of the flip-flop stage: its state
//    register is built from edge-triggered D flip-flops.
//  - Feeds cascaded counters (TC -> next EN) and display/decoder stages.
// PARAMETERS
//  WIDTH    4    state/data width in bits
//  MODULUS  10   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PORTS
//  C    in   1      clock; state updates on rising edge only
//  CLR  in   1      asynchronous clear, active-high
//  EN   in   1      count enable
//  LD   in   1      synchronous parallel load
//  UP   in   1      direction: 1 = up, 0 = down
//  D    in   WIDTH  parallel load value
//  Q    out  WIDTH  current count
//  TC   out  1      terminal count (combinational)
// BEHAVIOUR
//  Clock and reset (already decided):
//  - One clock, C; reset is asynchronous and active-high.
//  - CLR=1 forces Q=0 immediately, independent of C, and holds it while
//    asserted.
//  - CLR=0 is released synchronously: the first rising edge of C after
//    release applies normal behaviour.
//  - Reset values: Q=0, TC = (!UP && EN).
//  Priority at rising edge of C: CLR > LD > EN > hold.
//  - LD=1: Q <= D. LD overrides EN; LD=1 with EN=1 loads and does not count.
//  - EN=1, UP=1: Q <= (Q >= MODULUS-1) ? 0 : Q+1.
//  - EN=1, UP=0: Q <= (Q == 0 || Q >= MODULUS) ? MODULUS-1 : Q-1.
//  - EN=0, LD=0: Q holds.
//  Out-of-range states:
//  - A load with D >= MODULUS stores D unchanged.
//  - The next count edge returns Q to the range: to 0 counting up, to
//    MODULUS-1 counting down.
//  - Q must never exceed MODULUS-1 except by such a load.
//  TC = EN && ((UP && Q >= MODULUS-1) || (!UP && Q == 0)).
//  - TC is purely combinational; it is high during the cycle before
//    wrap-around.
//  - LD does not mask TC.
//  Latency: 1 edge from EN/LD to Q; 0 from CLR to Q; 0 from Q/EN/UP to TC.
//  UP may change every cycle; it is sampled only at the rising edge.
//  CLR asserted mid-count: Q=0 at once. The count restarts from 0 on the
//  first edge after release.
//  No glitches on Q between edges. TC may glitch while Q or UP settle, so
//  downstream logic samples TC only on C.
// STRUCTURE
//  Shared include file counter_defs.v (`define):
//  - default WIDTH and MODULUS
//  - direction codes DIR_UP=1'b1, DIR_DOWN=1'b0
//  Sub-module dff_ac, instantiated WIDTH times:
//  - edge-triggered D flip-flop with asynchronous clear
//  - ports Q, NQ, D, C, CLR
//  Next-state logic and TC are gate/continuous-assign logic around the
//  dff_ac bank. No behavioural counter.
// TESTING
//  Bench: C toggles every 7 time units; MODULUS=10, WIDTH=4; $monitor on
//  C, CLR, EN, LD, UP, D, Q, TC.
//  1 Reset:  CLR=1 at t=3 (mid-cycle) -> Q=0 before the next edge; hold
//            CLR=1 over 2 edges with EN=1 -> Q stays 0.
//  2 Up:     EN=1, UP=1 from Q=0, 12 edges -> Q=1..9,0,1,2; TC=1 only
//            while Q=9.
//  3 Down:   EN=1, UP=0 from Q=2, 4 edges -> Q=1,0,9,8; TC=1 only while
//            Q=0.
//  4 Load:   LD=1, EN=1, D=6 -> Q=6 after 1 edge, no count.
//            LD=1, D=13 -> Q=13; then EN=1, UP=1 -> Q=0.
//            Repeat the load of 13, then UP=0 -> Q=9.
//  5 Hold:   EN=0, LD=0 for 3 edges at Q=4 -> Q=4; TC=0 with Q=9 and EN=0.
//  6 Reset mid-op: counting up at Q=7, pulse CLR for 3 time units between
//            edges -> Q=0 immediately; next edge with EN=1 -> Q=1.

Source files
------------

// File: rtl/updown_counter_mod_pkg.sv
// Shared defaults and direction codes for the modulo-N up/down counter.
package updown_counter_mod_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_mod_dff_ac.sv
// Edge-triggered D flip-flop with asynchronous active-high clear and
// complementary output.
module dff_ac (
    input  logic C,
    input  logic CLR,
    input  logic D,
    output logic Q,
    output logic NQ
);

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) Q <= 1'b0;
        else     Q <= D;
    end

    assign NQ = ~Q;

endmodule

// File: rtl/updown_counter_mod.sv
// Synchronous modulo-N up/down counter with parallel load, count enable and
// combinational terminal count, built as next-state logic around a DFF bank.
module updown_counter_mod
    import updown_counter_mod_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             EN,
    input  logic             LD,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC
);

    localparam logic [WIDTH-1:0] Q_TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic             at_top;
    logic             at_zero;
    logic             out_range;
    logic             dir_up;

    // at_top also covers out-of-range loaded values, so counting up wraps them to 0
    assign at_top    = (Q >= Q_TOP);
    assign at_zero   = &nq;
    assign out_range = ({1'b0, Q} >= MOD_EXT);
    assign dir_up    = (UP == DIR_UP);

    assign inc_val = at_top ? '0 : (Q + WIDTH'(1));
    assign dec_val = (at_zero || out_range) ? Q_TOP : (Q - WIDTH'(1));

    assign nxt = LD ? D :
                 EN ? (dir_up ? inc_val : dec_val) :
                      Q;

    assign TC = EN && ((dir_up && at_top) || (!dir_up && at_zero));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_ac u_bit (
            .C  (C),
            .CLR(CLR),
            .D  (nxt[i]),
            .Q  (Q[i]),
            .NQ (nq[i])
        );
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_updown_counter_mod;

    localparam int W = 4;
    localparam int M = 10;

    logic         C = 1'b0;
    logic         CLR = 1'b0;
    logic         EN = 1'b0;
    logic         LD = 1'b0;
    logic         UP = 1'b1;
    logic [W-1:0] D = '0;
    logic [W-1:0] Q;
    logic         TC;

    int checks = 0;
    int failures = 0;
    int m = 0;
    bit armed = 1'b0;

    updown_counter_mod #(.WIDTH(W), .MODULUS(M)) dut (
        .C  (C),
        .CLR(CLR),
        .EN (EN),
        .LD (LD),
        .UP (UP),
        .D  (D),
        .Q  (Q),
        .TC (TC)
    );

    always #7 C = ~C;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour straight from the counting rules
    always @(posedge C or posedge CLR) begin
        if (CLR)      m <= 0;
        else if (LD)  m <= int'(D);
        else if (EN) begin
            if (UP) m <= (m >= M - 1) ? 0 : m + 1;
            else    m <= (m == 0 || m >= M) ? M - 1 : m - 1;
        end
    end

    function automatic int tc_of(input int q, input bit en, input bit up);
        return int'(en && ((up && q >= M - 1) || (!up && q == 0)));
    endfunction

    always @(negedge C) begin
        if (armed) begin
            chk("q_vs_model", int'(Q), m);
            chk("tc_vs_model", int'(TC), tc_of(m, EN, UP));
        end
    end

    task automatic set_in(input bit en, input bit ld, input bit up, input int d);
        @(negedge C);
        #1;
        EN = en; LD = ld; UP = up; D = W'(d);
    endtask

    task automatic edge_chk(input string name, input int exp_q, input int exp_tc);
        @(posedge C);
        #1;
        chk(name, int'(Q), exp_q);
        chk({name, "_tc"}, int'(TC), exp_tc);
    endtask

    initial begin
        int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int dn_seq[4]  = '{1, 0, 9, 8};

        // Reset asserted mid-cycle, held across two edges with EN=1
        EN = 1'b1; UP = 1'b1;
        #3 CLR = 1'b1;
        #1 chk("reset_immediate", int'(Q), 0);
        chk("reset_tc", int'(TC), 0);
        @(posedge C); @(posedge C);
        #1 chk("reset_hold", int'(Q), 0);
        @(negedge C);
        #1 CLR = 1'b0;
        armed = 1'b1;

        foreach (up_seq[i]) edge_chk("count_up", up_seq[i], int'(up_seq[i] == 9));

        set_in(1, 0, 0, 0);
        foreach (dn_seq[i]) edge_chk("count_down", dn_seq[i], int'(dn_seq[i] == 0));

        // Load overrides enable; out-of-range loads recover on the next count
        set_in(1, 1, 1, 6);
        edge_chk("load_6", 6, 0);
        set_in(1, 1, 1, 13);
        edge_chk("load_13", 13, 1);
        set_in(1, 0, 1, 0);
        edge_chk("oor_up", 0, 0);
        set_in(1, 1, 1, 13);
        edge_chk("reload_13", 13, 1);
        set_in(1, 0, 0, 0);
        #1 chk("oor_down_tc", int'(TC), 0);
        edge_chk("oor_down", 9, 0);

        set_in(1, 1, 1, 4);
        edge_chk("load_4", 4, 0);
        set_in(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) edge_chk("hold_4", 4, 0);
        set_in(1, 1, 1, 9);
        edge_chk("load_9", 9, 1);
        set_in(0, 0, 1, 0);
        #1 chk("tc_masked_by_en", int'(TC), 0);

        // Clear pulse between edges while counting up from 7
        set_in(1, 1, 1, 6);
        edge_chk("load_6b", 6, 0);
        set_in(1, 0, 1, 0);
        edge_chk("count_to_7", 7, 0);
        #2 CLR = 1'b1;
        #1 chk("clr_mid_cycle", int'(Q), 0);
        #2 CLR = 1'b0;
        edge_chk("restart_after_clr", 1, 0);

        // Randomized traffic checked by the compare process
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 1), $urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                #2 CLR = 1'b1;
                #1 chk("rand_clr", int'(Q), 0);
                #1 CLR = 1'b0;
            end
        end

        @(negedge C);
        #1;
        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
